// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor for RV64 B-type branches: global history XOR PC indexes a table
// of 2-bit saturating counters; repairs speculative history and redirects on mispredict.
module branch_predictor_gshare #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned PHT_ENTRIES = 256,
   parameter int unsigned GHR_BITS    = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                if_valid,
   input  logic [XLEN-1:0]     if_pc,
   input  logic [31:0]         if_instr,
   output logic [XLEN-1:0]     next_pc,
   output logic                pred_taken,
   output logic [GHR_BITS-1:0] pred_ghr,
   input  logic                res_valid,
   input  logic [XLEN-1:0]     res_pc,
   input  logic                res_taken,
   input  logic [XLEN-1:0]     res_target,
   input  logic                res_pred_taken,
   input  logic [GHR_BITS-1:0] res_ghr,
   output logic                redirect,
   output logic [XLEN-1:0]     redirect_pc,
   output logic [CNT_W-1:0]    branch_count,
   output logic [CNT_W-1:0]    mispredict_count
);

   localparam int unsigned IDX_W    = $clog2(PHT_ENTRIES);
   localparam logic [6:0]  OpBranch = 7'b1100011;

   logic                is_br;
   logic [XLEN-1:0]     imm;
   logic [IDX_W-1:0]    lookup_idx;
   logic [IDX_W-1:0]    update_idx;
   logic [1:0]          pht_q [PHT_ENTRIES];
   logic [1:0]          upd_cur;
   logic [1:0]          upd_next;
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;
   logic [CNT_W-1:0]    branch_cnt_q;
   logic [CNT_W-1:0]    mispredict_cnt_q;
   logic                unused_instr_bits;

   // Register/funct3 fields do not affect direction or target.
   assign unused_instr_bits = ^if_instr[24:12];

   // ---------------------------------------------------------------------------------------
   // Lookup (combinational, same cycle as fetch)
   // ---------------------------------------------------------------------------------------
   assign is_br = if_valid & (if_instr[6:0] == OpBranch);
   assign imm   = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8],
                   1'b0};

   assign lookup_idx = if_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign pred_taken = is_br & pht_q[lookup_idx][1];
   assign next_pc    = pred_taken ? (if_pc + imm) : (if_pc + XLEN'(4));
   assign pred_ghr   = ghr_q;

   // ---------------------------------------------------------------------------------------
   // Resolution and redirect
   // ---------------------------------------------------------------------------------------
   assign redirect    = res_valid & (res_taken ^ res_pred_taken);
   assign redirect_pc = res_taken ? res_target : (res_pc + XLEN'(4));
   assign update_idx  = res_pc[IDX_W+1:2] ^ IDX_W'(res_ghr);

   always_comb begin
      upd_cur  = pht_q[update_idx];
      upd_next = upd_cur;
      if (res_taken) begin
         if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
      end else begin
         if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
      end
   end

   // Lookup reads the pre-edge table, so a same-cycle update to the same entry is not bypassed.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
            pht_q[i] <= 2'b01;
         end
      end else if (res_valid) begin
         pht_q[update_idx] <= upd_next;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Speculative global history
   // ---------------------------------------------------------------------------------------
   // A redirect means the current IF instruction is wrong-path, so its shift is dropped.
   always_comb begin
      ghr_d = ghr_q;
      if (redirect) begin
         ghr_d = {res_ghr[GHR_BITS-2:0], res_taken};
      end else if (is_br && !stall) begin
         ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Performance counters (wrap naturally)
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (res_valid) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         if (redirect)  mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
   end

   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispredict_cnt_q;

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the single-bit IF-stage predictor: gshare direction predictor (global history XOR PC indexing a table of 2-bit saturating counters) for RV64 B-type branches.
- Sits beside the IF stage. Produces the predicted next PC combinationally and checkpoints the history per branch.
- Accepts resolution from ID/EX, repairs speculative history, and raises redirect on mispredict.
- Also provides free-running branch and mispredict counters for performance measurement.

Parameters:
- XLEN, 64, address/PC width.
- PHT_ENTRIES, 256, number of 2-bit counters; power of two, ≥ 4.
- GHR_BITS, 8, global history length; must be ≤ log2(PHT_ENTRIES).
- CNT_W, 32, width of the perf counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  pipeline stall; freezes all speculative state updates from IF.
- if_valid  in  1  if_instr/if_pc valid this cycle.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_instr  in  32  fetched instruction.
- next_pc  out  XLEN  predicted next fetch PC.
- pred_taken  out  1  prediction for the current IF branch; 0 if not a branch.
- pred_ghr  out  GHR_BITS  GHR value used for this lookup; pipelined alongside the branch.
- res_valid  in  1  a branch resolves this cycle.
- res_pc  in  XLEN  PC of the resolving branch.
- res_taken  in  1  actual outcome.
- res_target  in  XLEN  actual taken target.
- res_pred_taken  in  1  prediction made for this branch.
- res_ghr  in  GHR_BITS  pred_ghr captured at prediction time.
- redirect  out  1  mispredict; flush younger instructions and fetch redirect_pc.
- redirect_pc  out  XLEN  correct next PC.
- branch_count  out  CNT_W  resolved branches since reset.
- mispredict_count  out  CNT_W  mispredicts since reset.

Behaviour:
- Branch detect: is_br = if_valid & (if_instr[6:0] == 7'b1100011).
- Branch immediate: imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- Index: IDX_W = log2(PHT_ENTRIES).
  - Lookup index = if_pc[IDX_W+1:2] XOR zero-extended ghr.
  - Update index = res_pc[IDX_W+1:2] XOR zero-extended res_ghr.
- Prediction is combinational in the same cycle:
  - pred_taken = is_br & pht[idx][1].
  - next_pc = pred_taken ? if_pc + imm : if_pc + 4, modulo 2^XLEN.
  - pred_ghr = ghr (value before any shift this cycle).
- Speculative GHR, registered. Priority order each cycle:
  1. rst: ghr <= 0.
  2. redirect: ghr <= {res_ghr[GHR_BITS-2:0], res_taken}; this overrides any IF shift in the same cycle, because the IF instruction is wrong-path.
  3. is_br & ~stall: ghr <= {ghr[GHR_BITS-2:0], pred_taken}.
  4. Otherwise hold.
- PHT update on res_valid, independent of stall:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
  - Written at the clock edge.
- Same-cycle lookup and update of the same index: lookup returns the old value (no bypass).
- Redirect (combinational from resolve inputs):
  - redirect = res_valid & (res_taken != res_pred_taken).
  - redirect_pc = res_taken ? res_target : res_pc + 4.
  - The same-cycle next_pc is not altered; the fetch mux gives redirect priority.
- Perf counters:
  - branch_count increments on each res_valid.
  - mispredict_count increments on each redirect.
  - Both wrap modulo 2^CNT_W.
- Reset (synchronous):
  - All PHT counters <= 2'b01 (weakly not-taken); ghr <= 0; both counters <= 0.
  - Combinational outputs follow their inputs during reset.
  - Reset asserted mid-training discards all history.

Test Plan:
- After reset, if_valid=1, if_pc=0x1000, BEQ with imm=+16 -> pred_taken=0, next_pc=0x1004, pred_ghr=0. Same cycle with non-branch instr -> pred_taken=0, no GHR shift.
- Resolve that branch: res_pc=0x1000, res_ghr=0, res_taken=1, res_pred_taken=0, res_target=0x1010 -> redirect=1, redirect_pc=0x1010, ghr=0x01 next cycle, mispredict_count=1. Re-lookup with ghr forced 0 via reset-free replay -> counter now 2'b10, pred_taken=1, next_pc=0x1010.
- Saturation: three taken resolves at one index, then one not-taken -> counter 11 then 10, prediction stays taken; two more not-taken -> 00, one further -> stays 00.
- stall=1 with an IF branch -> ghr unchanged. Same cycle redirect plus IF branch -> ghr = {res_ghr, res_taken}, IF shift dropped.
- Alternating T/N pattern at one PC for 64 resolves with correct res_ghr feedback -> mispredict_count stops incrementing after warm-up (history disambiguates). branch_count=64.
- Assert rst after training -> all lookups predict not-taken, ghr=0, counters=0. Also run with PHT_ENTRIES=16, GHR_BITS=4 to check index truncation.
